// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory port between an
// instruction-fetch requester (port 0) and a load/store requester (port 1).
module mem_port_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAT_CNT = 4'(MEM_LAT);

  state_t            state, state_nxt;
  logic              sel_q, last_gnt;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              any_req, win, cur_we, wait_exit;

  // On a conflict the port not granted last wins.
  assign any_req   = req0 | req1;
  assign win       = (req0 & req1) ? ~last_gnt : req1;
  assign cur_we    = sel_q ? we1 : we0;
  assign wait_exit = (cnt == 4'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (wait_exit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_en = 1'b0;
    mem_we = 1'b0;
    done0  = 1'b0;
    done1  = 1'b0;
    busy   = 1'b1;
    case (state)
      S_IDLE:  busy = 1'b0;
      S_ISSUE: begin
        mem_en = 1'b1;
        mem_we = cur_we;
      end
      S_DONE: begin
        done0 = ~sel_q;
        done1 = sel_q;
      end
      default: ;
    endcase
  end

  // Counter is loaded in ISSUE and the read is captured on the edge it hits 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= 1'b0;
      last_gnt <= 1'b1;
      cnt      <= 4'd0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (any_req) begin
          sel_q    <= win;
          last_gnt <= win;
        end
        S_ISSUE: cnt <= LAT_CNT;
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (wait_exit && !cur_we) begin
            if (sel_q) rdata1_q <= mem_rdata;
            else       rdata0_q <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign sel       = sel_q;
  assign mem_addr  = sel_q ? addr1 : addr0;
  assign mem_wdata = sel_q ? wdata1 : wdata0;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (latency 1 and 4), a transaction
// level model checked every cycle, plus directed literal checks.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  req0, req1, we0, we1;
  logic [31:0] addr0 [2], addr1 [2], wdata0 [2], wdata1 [2];
  logic [31:0] rdata0 [2], rdata1 [2], mem_addr [2], mem_wdata [2], mem_rdata [2];
  logic [1:0]  done0, done1, sel, mem_en, mem_we, busy;
  logic [31:0] pipe [2][4];
  int          cyc = 0;
  bit          chk_en = 1'b0;
  int          n_run = 0;
  int          n_fail = 0;

  mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
    .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
    .done0(done0[0]), .done1(done1[0]), .rdata0(rdata0[0]), .rdata1(rdata1[0]),
    .sel(sel[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0]));

  mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(4)) u_dut_l4 (
    .clk(clk), .rst(rst), .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
    .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
    .done0(done0[1]), .done1(done1[1]), .rdata0(rdata0[1]), .rdata1(rdata1[1]),
    .sel(sel[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1]));

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Memory: read data appears exactly MEM_LAT cycles after mem_en, junk otherwise.
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][3];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      for (int s = 3; s > 0; s--) pipe[i][s] <= pipe[i][s-1];
      pipe[i][0] <= (mem_en[i] && !mem_we[i]) ? mem_fn(mem_addr[i]) : (32'hBAD00000 ^ cyc);
    end
  end

  // Transaction model: a grant in cycle t means mem_en at t+1, capture at the
  // end of t+1+LAT, done at t+2+LAT, idle again at t+3+LAT.
  bit          m_act [2], m_port [2], m_we [2], m_last [2], m_sel [2];
  int          m_tg [2];
  logic [31:0] m_addr [2], m_wd [2], m_rd0 [2], m_rd1 [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int   k, lt;
      logic e_en, e_d0, e_d1;
      lt   = lat_of(i);
      k    = cyc - m_tg[i];
      e_en = m_act[i] && (k == 1);
      e_d0 = m_act[i] && (k == lt + 2) && !m_port[i];
      e_d1 = m_act[i] && (k == lt + 2) && m_port[i];
      if (chk_en) begin
        chkb($sformatf("L%0d busy c%0d", lt, cyc), busy[i], m_act[i]);
        chkb($sformatf("L%0d mem_en c%0d", lt, cyc), mem_en[i], e_en);
        chkb($sformatf("L%0d done0 c%0d", lt, cyc), done0[i], e_d0);
        chkb($sformatf("L%0d done1 c%0d", lt, cyc), done1[i], e_d1);
        chkb($sformatf("L%0d sel c%0d", lt, cyc), sel[i], m_sel[i]);
        chk($sformatf("L%0d rdata0 c%0d", lt, cyc), rdata0[i], m_rd0[i]);
        chk($sformatf("L%0d rdata1 c%0d", lt, cyc), rdata1[i], m_rd1[i]);
        if (e_en) begin
          chkb($sformatf("L%0d mem_we c%0d", lt, cyc), mem_we[i], m_we[i]);
          chk($sformatf("L%0d mem_addr c%0d", lt, cyc), mem_addr[i], m_addr[i]);
          chk($sformatf("L%0d mem_wdata c%0d", lt, cyc), mem_wdata[i], m_wd[i]);
        end
      end
      if (rst) begin
        m_act[i] = 1'b0; m_sel[i] = 1'b0; m_last[i] = 1'b1;
        m_rd0[i] = '0;   m_rd1[i] = '0;
      end else if (m_act[i]) begin
        if (k == lt + 1 && !m_we[i]) begin
          if (m_port[i]) m_rd1[i] = mem_fn(m_addr[i]);
          else           m_rd0[i] = mem_fn(m_addr[i]);
        end
        if (k == lt + 2) m_act[i] = 1'b0;
      end else if (req0[i] || req1[i]) begin
        m_port[i] = (req0[i] && req1[i]) ? !m_last[i] : req1[i];
        m_last[i] = m_port[i];
        m_sel[i]  = m_port[i];
        m_act[i]  = 1'b1;
        m_tg[i]   = cyc;
        m_we[i]   = m_port[i] ? we1[i] : we0[i];
        m_addr[i] = m_port[i] ? addr1[i] : addr0[i];
        m_wd[i]   = m_port[i] ? wdata1[i] : wdata0[i];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int i, input bit p, input int max_c, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(p ? done1[i] : done0[i]) && n < max_c);
    chkb($sformatf("wait done%0d inst%0d", p, i), p ? done1[i] : done0[i], 1'b1);
  endtask

  initial begin
    int   sels [$];
    int   dts [$];
    int   n, bcnt, dc, dn, en;
    req0 = '0; req1 = '0; we0 = '0; we1 = '0;
    for (int i = 0; i < 2; i++) begin
      addr0[i] = '0; addr1[i] = '0; wdata0[i] = '0; wdata1[i] = '0;
      m_act[i] = 1'b0; m_sel[i] = 1'b0; m_last[i] = 1'b1; m_tg[i] = 0;
      m_rd0[i] = '0; m_rd1[i] = '0; m_port[i] = 1'b0; m_we[i] = 1'b0;
      m_addr[i] = '0; m_wd[i] = '0;
    end
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    chkb("reset busy", busy[0], 1'b0);
    chkb("reset sel", sel[0], 1'b0);
    chkb("reset mem_en", mem_en[0], 1'b0);
    chk("reset rdata0", rdata0[0], 32'h0);
    chk("reset rdata1", rdata1[1], 32'h0);
    step();
    rst = 1'b0;

    // Single read, latency 1
    req0[0] = 1'b1; addr0[0] = 32'h100;
    step();
    chkb("t1 mem_en C1", mem_en[0], 1'b1);
    chk("t1 mem_addr C1", mem_addr[0], 32'h100);
    chkb("t1 sel C1", sel[0], 1'b0);
    step();
    chkb("t1 done0 C2", done0[0], 1'b0);
    step();
    chkb("t1 done0 C3", done0[0], 1'b1);
    chk("t1 rdata0 C3", rdata0[0], 32'hDEADBEEF);
    req0[0] = 1'b0;
    step();
    chkb("t1 busy C4", busy[0], 1'b0);

    // Conflict after reset: strict alternation starting with port 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0[0] = 1'b1; req1[0] = 1'b1; addr0[0] = 32'h40; addr1[0] = 32'h80;
    for (int c = 1; c <= 15; c++) begin
      step();
      if (mem_en[0]) sels.push_back(int'(sel[0]));
      if (done0[0] || done1[0]) dts.push_back(c);
    end
    req0[0] = 1'b0; req1[0] = 1'b0;
    chk("t2 grant count", sels.size(), 4);
    chk("t2 done count", dts.size(), 4);
    for (int j = 0; j < sels.size() && j < 4; j++)
      chk($sformatf("t2 grant %0d", j), sels[j], j % 2);
    for (int j = 0; j < dts.size() && j < 4; j++)
      chk($sformatf("t2 done cycle %0d", j), dts[j], 3 + 4 * j);
    step();
    chkb("t2 idle", busy[0], 1'b0);
    chk("t2 rdata0", rdata0[0], mem_fn(32'h40));

    // Write on port 1 leaves rdata1 alone
    req1[0] = 1'b1; we1[0] = 1'b1; addr1[0] = 32'h2000; wdata1[0] = 32'h12345678;
    step();
    chkb("t3 mem_we", mem_we[0], 1'b1);
    chk("t3 mem_wdata", mem_wdata[0], 32'h12345678);
    chk("t3 mem_addr", mem_addr[0], 32'h2000);
    step();
    step();
    chkb("t3 done1", done1[0], 1'b1);
    chk("t3 rdata1 kept", rdata1[0], mem_fn(32'h80));
    req1[0] = 1'b0; we1[0] = 1'b0;
    step();

    // Latency 4 read
    req0[1] = 1'b1; addr0[1] = 32'h300;
    bcnt = 0; dc = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (busy[1]) bcnt++;
      if (done0[1]) dc = c;
      if (c == 5) chk("t4 rdata0 before capture", rdata0[1], 32'h0);
      if (c == 6) begin
        chk("t4 rdata0 at done", rdata0[1], mem_fn(32'h300));
        req0[1] = 1'b0;
      end
    end
    chk("t4 busy cycles", bcnt, 6);
    chk("t4 done cycle", dc, 6);

    // Reset one cycle into WAIT
    req1[1] = 1'b1; addr1[1] = 32'h500;
    step();
    step();
    rst = 1'b1; req1[1] = 1'b0;
    step();
    rst = 1'b0;
    chkb("t5 busy", busy[1], 1'b0);
    chkb("t5 sel", sel[1], 1'b0);
    chk("t5 rdata0", rdata0[1], 32'h0);
    dn = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (done1[1]) dn++;
    end
    chk("t5 no done", dn, 0);
    req0[1] = 1'b1; req1[1] = 1'b1; addr0[1] = 32'h700; addr1[1] = 32'h780;
    step();
    chkb("t5 conflict mem_en", mem_en[1], 1'b1);
    chkb("t5 conflict sel", sel[1], 1'b0);
    wait_done(1, 1'b0, 12, n);
    chk("t5 port0 done delay", n, 5);
    req0[1] = 1'b0;
    wait_done(1, 1'b1, 12, n);
    chk("t5 port1 done delay", n, 7);
    req1[1] = 1'b0;
    step();

    // Request dropped mid-transaction
    req1[1] = 1'b1; addr1[1] = 32'h600;
    step();
    step();
    req1[1] = 1'b0;
    dn = 0; en = 0;
    for (int c = 3; c <= 14; c++) begin
      step();
      if (done1[1]) dn++;
      if (mem_en[1]) en++;
    end
    chk("t6 done1 pulses", dn, 1);
    chk("t6 regrants", en, 0);
    chk("t6 rdata1", rdata1[1], mem_fn(32'h600));

    step();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
